// File: rtl/ps2_note_tracker.sv
// Parses PS/2 make/break/extended sequences and keeps a last-pressed-priority stack of held
// note keys; presents the divider half-period count of the newest held key (0 = silence).
module ps2_note_tracker #(
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         scan_byte,
    input  logic               scan_valid,
    output logic [COUNT_W-1:0] note_count,
    output logic               note_active,
    output logic               note_change,
    output logic [3:0]         held_cnt,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              stack_reg  [DEPTH];
    logic [7:0]              stack_next [DEPTH];
    logic [3:0]              cnt_reg, cnt_next;
    logic                    overrun_reg, overrun_next;
    logic [DEPTH-1:0]        hit, hit_at_or_below;
    logic [DEPTH-1:0][7:0]   above;
    logic [7:0]              top_code;
    logic [COUNT_W-1:0]      top_count;
    logic                    is_err, is_f0, is_e0, is_ignored, is_note;
    logic                    do_make, do_break;

    function automatic logic [COUNT_W-1:0] note_lookup(input logic [7:0] code);
        logic [19:0] c;
        case (code)
            8'h15: c = 20'h5D2EF;  8'h1D: c = 20'h530A8;  8'h24: c = 20'h49FB6;  8'h2D: c = 20'h45C12;
            8'h2C: c = 20'h3E47E;  8'h35: c = 20'h377C8;  8'h3C: c = 20'h316BD;  8'h43: c = 20'h2EA85;
            8'h1C: c = 20'h2EA85;  8'h1B: c = 20'h29918;  8'h23: c = 20'h25085;  8'h2B: c = 20'h22F44;
            8'h34: c = 20'h1F23F;  8'h33: c = 20'h1BBE4;  8'h3B: c = 20'h18B77;  8'h42: c = 20'h17544;
            8'h1A: c = 20'h17544;  8'h22: c = 20'h14C8B;  8'h21: c = 20'h12842;  8'h2A: c = 20'h117A2;
            8'h32: c = 20'h0F920;  8'h31: c = 20'h0DDF2;  8'h3A: c = 20'h0C5BB;  8'h41: c = 20'h0BA8B;
            default: c = 20'h00000;
        endcase
        return COUNT_W'(c);
    endfunction

    assign is_err     = (scan_byte == 8'h00) || (scan_byte == 8'hFF);
    assign is_f0      = (scan_byte == 8'hF0);
    assign is_e0      = (scan_byte == 8'hE0);
    assign is_ignored = (scan_byte == 8'hAA) || (scan_byte == 8'hFA) ||
                        (scan_byte == 8'hFE) || (scan_byte == 8'hEE);
    assign is_note    = (note_lookup(scan_byte) != '0);

    always_comb begin
        state_next = state_reg;
        do_make    = 1'b0;
        do_break   = 1'b0;
        if (scan_valid) begin
            if (is_err) begin
                state_next = IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (is_f0)            state_next = BRK;
                        else if (is_e0)       state_next = EXT;
                        else if (!is_ignored) do_make    = 1'b1;
                    end
                    BRK: begin
                        if (is_e0) begin
                            state_next = EXT_BRK;
                        end else if (!is_f0) begin
                            do_break   = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    EXT:     state_next = is_f0 ? EXT_BRK : IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Per-entry match against the incoming code and the value one slot above (for shifting down).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign hit[gi] = (4'(gi) < cnt_reg) && (stack_reg[gi] == scan_byte);
            if (gi == DEPTH - 1) begin : g_top
                assign above[gi] = 8'h00;
            end else begin : g_mid
                assign above[gi] = stack_reg[gi + 1];
            end
        end
    endgenerate

    always_comb begin
        logic seen;
        seen            = 1'b0;
        hit_at_or_below = '0;
        for (int i = 0; i < DEPTH; i++) begin
            seen               = seen | hit[i];
            hit_at_or_below[i] = seen;
        end
    end

    always_comb begin
        stack_next   = stack_reg;
        cnt_next     = cnt_reg;
        overrun_next = overrun_reg;
        if (scan_valid && is_err) begin
            cnt_next     = 4'd0;
            overrun_next = 1'b1;
        end else if (do_make && is_note && (hit == '0)) begin
            if (cnt_reg == 4'(DEPTH)) begin
                // Full: the oldest key falls off the bottom to make room.
                for (int i = 0; i < DEPTH; i++) stack_next[i] = above[i];
                stack_next[DEPTH-1] = scan_byte;
                overrun_next        = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (4'(i) == cnt_reg) stack_next[i] = scan_byte;
                cnt_next = cnt_reg + 4'd1;
            end
        end else if (do_break && (hit != '0)) begin
            for (int i = 0; i < DEPTH; i++)
                if (hit_at_or_below[i]) stack_next[i] = above[i];
            cnt_next = cnt_reg - 4'd1;
        end
    end

    always_comb begin
        top_code = 8'h00;
        for (int i = 0; i < DEPTH; i++)
            if (4'(i + 1) == cnt_reg) top_code = stack_reg[i];
    end

    assign top_count = note_lookup(top_code);
    assign overrun   = overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            overrun_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_reg[i] <= 8'h00;
            note_count  <= '0;
            note_active <= 1'b0;
            note_change <= 1'b0;
            held_cnt    <= 4'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            overrun_reg <= overrun_next;
            stack_reg   <= stack_next;
            note_count  <= top_count;
            note_change <= (top_count != note_count);
            note_active <= (cnt_reg != 4'd0);
            held_cnt    <= cnt_reg;
        end
    end

endmodule

// File: tb/tb_ps2_note_tracker.sv
// Scoreboard bench for ps2_note_tracker: a queue-based key model predicts every note_count change,
// and a monitor pops and compares on each note_change pulse.
module tb_ps2_note_tracker;
    localparam int DEPTH   = 4;
    localparam int COUNT_W = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         scan_byte = 8'h00;
    logic               scan_valid = 1'b0;
    logic [COUNT_W-1:0] note_count;
    logic               note_active;
    logic               note_change;
    logic [3:0]         held_cnt;
    logic               overrun;

    ps2_note_tracker #(.DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .scan_byte(scan_byte), .scan_valid(scan_valid),
        .note_count(note_count), .note_active(note_active), .note_change(note_change),
        .held_cnt(held_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [7:0]         held_q[$];
    logic [COUNT_W-1:0] exp_q[$];
    logic [COUNT_W-1:0] m_last = '0;
    logic [COUNT_W-1:0] mon_exp;
    bit                 m_brk = 0, m_ext = 0, m_ovr = 0;
    logic [7:0]         notes [24] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                                       8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
                                       8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41};
    logic [19:0]        pitches [24] = '{20'h5D2EF, 20'h530A8, 20'h49FB6, 20'h45C12, 20'h3E47E, 20'h377C8, 20'h316BD, 20'h2EA85,
                                         20'h2EA85, 20'h29918, 20'h25085, 20'h22F44, 20'h1F23F, 20'h1BBE4, 20'h18B77, 20'h17544,
                                         20'h17544, 20'h14C8B, 20'h12842, 20'h117A2, 20'h0F920, 20'h0DDF2, 20'h0C5BB, 20'h0BA8B};

    function automatic logic [COUNT_W-1:0] pitch(input logic [7:0] code);
        for (int i = 0; i < 24; i++)
            if (notes[i] == code) return pitches[i];
        return '0;
    endfunction

    function automatic logic [COUNT_W-1:0] model_top();
        if (held_q.size() == 0) return '0;
        return pitch(held_q[held_q.size()-1]);
    endfunction

    task automatic press_key(input logic [7:0] b);
        if (pitch(b) == '0) return;
        foreach (held_q[i]) if (held_q[i] == b) return;
        if (held_q.size() == DEPTH) begin
            void'(held_q.pop_front());
            m_ovr = 1;
        end
        held_q.push_back(b);
    endtask

    task automatic release_key(input logic [7:0] b);
        for (int i = 0; i < held_q.size(); i++)
            if (held_q[i] == b) begin
                held_q.delete(i);
                return;
            end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [COUNT_W-1:0] top;
        if (b == 8'h00 || b == 8'hFF) begin
            held_q.delete();
            m_ovr = 1; m_brk = 0; m_ext = 0;
        end else if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else m_ext = 0;
        end else if (m_brk) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b != 8'hF0) begin
                release_key(b);
                m_brk = 0;
            end
        end else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (!(b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE)) press_key(b);
        top = model_top();
        if (top != m_last) begin
            exp_q.push_back(top);
            m_last = top;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a negative edge; presents one byte for one cycle and updates the model.
    task automatic send(input logic [7:0] b);
        scan_byte  = b;
        scan_valid = 1'b1;
        model_byte(b);
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        repeat (3) @(negedge clk);
        check({tag, ".count"},  32'(note_count),  32'(model_top()));
        check({tag, ".held"},   32'(held_cnt),    32'(held_q.size()));
        check({tag, ".active"}, 32'(note_active), 32'(held_q.size() != 0));
        check({tag, ".ovr"},    32'(overrun),     32'(m_ovr));
    endtask

    always @(negedge clk) begin
        if (note_change) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL change_pulse: unexpected pulse with note_count=%0h, expected no change", note_count);
            end else begin
                mon_exp = exp_q.pop_front();
                if (note_count !== mon_exp) begin
                    errors++;
                    $display("FAIL change_value: got %0h, expected %0h", note_count, mon_exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        logic [7:0] b;
        int r;

        repeat (3) @(negedge clk);
        check("reset.count",  32'(note_count),  0);
        check("reset.active", 32'(note_active), 0);
        check("reset.change", 32'(note_change), 0);
        check("reset.held",   32'(held_cnt),    0);
        check("reset.ovr",    32'(overrun),     0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single key: latency of two edges, then release.
        send(8'h1C);
        check("t1.early", 32'(note_count), 0);
        @(negedge clk);
        check("t1.count", 32'(note_count), 32'h2EA85);
        check("t1.held",  32'(held_cnt), 1);
        send(8'hF0); send(8'h1C);
        settle_check("t1.release");
        check("t1.silent", 32'(note_count), 0);

        // Chords and middle-entry release.
        send(8'h1C); send(8'h33);
        settle_check("t2.chord");
        check("t2.a4", 32'(note_count), 32'h1BBE4);
        send(8'hF0); send(8'h33);
        settle_check("t2.brk33");
        check("t2.c4", 32'(note_count), 32'h2EA85);
        send(8'hF0); send(8'h1C);
        settle_check("t2.brk1c");
        send(8'h1C); send(8'h23); send(8'h33);
        settle_check("t2.three");
        p0 = pulses;
        send(8'hF0); send(8'h23);
        settle_check("t2.mid");
        check("t2.mid_count", 32'(note_count), 32'h1BBE4);
        check("t2.mid_pulses", 32'(pulses - p0), 0);
        send(8'hF0); send(8'h33); send(8'hF0); send(8'h1C);
        settle_check("t2.clear");

        // Typematic repeat, extended codes and unmapped codes.
        p0 = pulses;
        repeat (5) send(8'h1C);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h76);
        settle_check("t3");
        check("t3.held", 32'(held_cnt), 1);
        check("t3.pulses", 32'(pulses - p0), 1);
        check("t3.ovr", 32'(overrun), 0);
        send(8'hF0); send(8'h1C);

        // Overflow evicts the oldest key.
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        settle_check("t4.full");
        check("t4.held", 32'(held_cnt), 4);
        check("t4.ovr",  32'(overrun), 1);
        check("t4.g3",   32'(note_count), 32'h3E47E);
        send(8'hF0); send(8'h15);
        settle_check("t4.evicted");
        check("t4.g3b", 32'(note_count), 32'h3E47E);
        foreach (notes[i]) begin send(8'hF0); send(notes[i]); end
        settle_check("t4.clear");

        // Error byte flushes the stack and leaves the parser idle.
        send(8'h1C);
        settle_check("t5.press");
        send(8'hFF);
        settle_check("t5.err");
        check("t5.count", 32'(note_count), 0);
        check("t5.ovr",   32'(overrun), 1);
        send(8'hF0); send(8'hF0); send(8'h1C);
        settle_check("t5.brk");
        send(8'h1C);
        settle_check("t5.replay");
        check("t5.c4", 32'(note_count), 32'h2EA85);

        // Asynchronous reset mid-sequence.
        send(8'hF0);
        check("t6.pending", 32'(exp_q.size()), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6.count",  32'(note_count),  0);
        check("t6.active", 32'(note_active), 0);
        check("t6.change", 32'(note_change), 0);
        check("t6.held",   32'(held_cnt),    0);
        check("t6.ovr",    32'(overrun),     0);
        held_q.delete(); exp_q.delete();
        m_brk = 0; m_ext = 0; m_ovr = 0; m_last = '0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send(8'h1C);
        settle_check("t6.make");
        check("t6.c4", 32'(note_count), 32'h2EA85);

        // Randomised traffic with back-to-back strobes and idle gaps.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      b = notes[$urandom_range(0, 23)];
            else if (r < 75) b = 8'hF0;
            else if (r < 82) b = 8'hE0;
            else if (r < 99) b = 8'($urandom_range(1, 254));
            else             b = 8'hFF;
            send(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            if (n % 25 == 24) settle_check("rand");
        end
        settle_check("rand.end");
        check("final.pending", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
